// File: rtl/fp_sqrt_scheduler.sv
// rtl/fp_sqrt_scheduler.sv - round-robin scheduler for a shared multi-cycle FP square-root unit
module fp_sqrt_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int EXP_WIDTH  = 11,
  parameter int FRAC_WIDTH = 52,
  parameter int TIMEOUT    = 64
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ-1:0]              req_sign_i,
  input  logic [NUM_REQ*EXP_WIDTH-1:0]    req_exp_i,
  input  logic [NUM_REQ*FRAC_WIDTH-1:0]   req_frac_i,
  output logic                            resp_valid_o,
  input  logic                            resp_ready_i,
  output logic [$clog2(NUM_REQ)-1:0]      resp_id_o,
  output logic                            resp_sign_o,
  output logic [EXP_WIDTH-1:0]            resp_exp_o,
  output logic [FRAC_WIDTH-1:0]           resp_frac_o,
  output logic                            resp_flag_inv_o,
  output logic                            resp_flag_err_o,
  output logic                            u_start_o,
  output logic                            u_sign_o,
  output logic [EXP_WIDTH-1:0]            u_exp_o,
  output logic [FRAC_WIDTH-1:0]           u_frac_o,
  input  logic                            u_done_i,
  input  logic [EXP_WIDTH-1:0]            u_res_exp_i,
  input  logic [FRAC_WIDTH-1:0]           u_res_frac_i,
  output logic                            u_abort_o
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam logic [EXP_WIDTH-1:0]  EXP_ONES  = {EXP_WIDTH{1'b1}};
  localparam logic [FRAC_WIDTH-1:0] QNAN_FRAC = {1'b1, {(FRAC_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLASSIFY = 3'd1,
    S_ISSUE    = 3'd2,
    S_WAIT     = 3'd3,
    S_RESP     = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic                  op_sign_q, op_sign_d;
  logic [EXP_WIDTH-1:0]  op_exp_q, op_exp_d;
  logic [FRAC_WIDTH-1:0] op_frac_q, op_frac_d;
  logic                  res_sign_q, res_sign_d;
  logic [EXP_WIDTH-1:0]  res_exp_q, res_exp_d;
  logic [FRAC_WIDTH-1:0] res_frac_q, res_frac_d;
  logic                  inv_q, inv_d;
  logic                  err_q, err_d;

  logic                  gnt_found;
  logic [ID_W-1:0]       gnt_id;
  logic [ID_W-1:0]       cand;
  logic                  unit_busy;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  // Next-state, datapath updates and handshake outputs for the operation FSM.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    timer_d     = timer_q;
    id_d        = id_q;
    op_sign_d   = op_sign_q;
    op_exp_d    = op_exp_q;
    op_frac_d   = op_frac_q;
    res_sign_d  = res_sign_q;
    res_exp_d   = res_exp_q;
    res_frac_d  = res_frac_q;
    inv_d       = inv_q;
    err_d       = err_q;
    req_ready_o = '0;
    u_start_o   = 1'b0;
    u_abort_o   = 1'b0;
    resp_valid_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          req_ready_o[gnt_id] = 1'b1;
          id_d      = gnt_id;
          op_sign_d = req_sign_i[gnt_id];
          op_exp_d  = req_exp_i[int'(gnt_id)*EXP_WIDTH +: EXP_WIDTH];
          op_frac_d = req_frac_i[int'(gnt_id)*FRAC_WIDTH +: FRAC_WIDTH];
          state_d   = S_CLASSIFY;
        end
      end
      S_CLASSIFY: begin
        state_d = S_RESP;
        if (op_exp_q == '0) begin
          // zeros and denormals (flushed) keep their sign
          res_sign_d = op_sign_q;
          res_exp_d  = '0;
          res_frac_d = '0;
        end else if (op_exp_q == EXP_ONES && op_frac_q != '0) begin
          res_sign_d = 1'b0;
          res_exp_d  = EXP_ONES;
          res_frac_d = QNAN_FRAC;
          inv_d      = 1'b1;
        end else if (op_sign_q) begin
          res_sign_d = 1'b0;
          res_exp_d  = EXP_ONES;
          res_frac_d = QNAN_FRAC;
          inv_d      = 1'b1;
        end else if (op_exp_q == EXP_ONES) begin
          res_sign_d = 1'b0;
          res_exp_d  = EXP_ONES;
          res_frac_d = '0;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        u_start_o = 1'b1;
        timer_d   = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        // a done arriving on the timeout cycle still counts as a good result
        if (u_done_i) begin
          res_sign_d = 1'b0;
          res_exp_d  = u_res_exp_i;
          res_frac_d = u_res_frac_i;
          state_d    = S_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          u_abort_o  = 1'b1;
          res_sign_d = 1'b0;
          res_exp_d  = EXP_ONES;
          res_frac_d = QNAN_FRAC;
          err_d      = 1'b1;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) begin
          rr_ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
          inv_d    = 1'b0;
          err_d    = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      timer_q    <= '0;
      id_q       <= '0;
      op_sign_q  <= 1'b0;
      op_exp_q   <= '0;
      op_frac_q  <= '0;
      res_sign_q <= 1'b0;
      res_exp_q  <= '0;
      res_frac_q <= '0;
      inv_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      timer_q    <= timer_d;
      id_q       <= id_d;
      op_sign_q  <= op_sign_d;
      op_exp_q   <= op_exp_d;
      op_frac_q  <= op_frac_d;
      res_sign_q <= res_sign_d;
      res_exp_q  <= res_exp_d;
      res_frac_q <= res_frac_d;
      inv_q      <= inv_d;
      err_q      <= err_d;
    end
  end

  assign unit_busy = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign u_sign_o  = unit_busy & op_sign_q;
  assign u_exp_o   = unit_busy ? op_exp_q  : '0;
  assign u_frac_o  = unit_busy ? op_frac_q : '0;

  assign resp_id_o       = id_q;
  assign resp_sign_o     = res_sign_q;
  assign resp_exp_o      = res_exp_q;
  assign resp_frac_o     = res_frac_q;
  assign resp_flag_inv_o = inv_q;
  assign resp_flag_err_o = err_q;

endmodule
